// File: rtl/sa_1d_window_feeder_if.sv
// Bundle of the sequence-control, sample-stream and window-beat signals of sa_1d_window_feeder.
// The slave modport is the feeder's view; the master modport is the view of the block driving it.
interface sa_1d_window_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = 8
);
  logic                  start;
  logic [LEN_W-1:0]      seq_len;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  win_valid;
  logic [DATA_WIDTH-1:0] win_d0;
  logic [DATA_WIDTH-1:0] win_d1;
  logic [DATA_WIDTH-1:0] win_d2;
  logic                  busy;
  logic                  done;
  logic [LEN_W-1:0]      win_count;

  modport master (
    output start, seq_len, s_valid, s_data,
    input  s_ready, win_valid, win_d0, win_d1, win_d2, busy, done, win_count
  );

  modport slave (
    input  start, seq_len, s_valid, s_data,
    output s_ready, win_valid, win_d0, win_d1, win_d2, busy, done, win_count
  );
endinterface

// File: rtl/sa_1d_window_feeder.sv
// Sliding 3-sample window builder feeding the sa_1d systolic array, with sequence framing.
// Optional "same" zero padding is enabled by defining SA_WINDOW_ZERO_PAD_EN.
module sa_1d_window_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned STRIDE     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sa_1d_window_feeder_if.slave bus
);

`ifdef SA_WINDOW_ZERO_PAD_EN
  localparam int unsigned MIN_LEN  = 1;
  localparam int unsigned FILL_CNT = 1;
  typedef enum logic [2:0] {IDLE, FILL, STREAM, FLUSH, DONE} state_t;
`else
  localparam int unsigned MIN_LEN  = 3;
  localparam int unsigned FILL_CNT = 2;
  typedef enum logic [2:0] {IDLE, FILL, STREAM, DONE} state_t;
`endif

  localparam int unsigned     PH_W    = 2;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STRIDE - 1);

  state_t                state;
  logic [LEN_W-1:0]      len;
  logic [LEN_W-1:0]      cnt;
  logic [LEN_W-1:0]      win_count;
  logic [PH_W-1:0]       phase;
  logic [DATA_WIDTH-1:0] sr1;
  logic [DATA_WIDTH-1:0] sr2;
  logic [DATA_WIDTH-1:0] win_d0;
  logic [DATA_WIDTH-1:0] win_d1;
  logic [DATA_WIDTH-1:0] win_d2;
  logic                  win_valid;
  logic                  busy;
  logic                  done;

  logic                  ready_c;
  logic                  accept_c;
  logic                  last_c;
  logic                  emit_c;
  logic [PH_W-1:0]       phase_nxt_c;

  // Ready depends only on state and remaining count, never on s_valid.
  assign ready_c     = (state == FILL) || ((state == STREAM) && (cnt < len));
  assign accept_c    = bus.s_valid && ready_c;
  assign last_c      = (cnt == (len - LEN_W'(1)));
  assign emit_c      = (phase == '0);
  assign phase_nxt_c = (phase == PH_LAST) ? '0 : (phase + PH_W'(1));

  assign bus.s_ready   = ready_c;
  assign bus.win_valid = win_valid;
  assign bus.win_d0    = win_d0;
  assign bus.win_d1    = win_d1;
  assign bus.win_d2    = win_d2;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.win_count = win_count;

  // Sequencer, shift register and registered window beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      phase     <= '0;
      sr1       <= '0;
      sr2       <= '0;
      win_valid <= 1'b0;
      win_d0    <= '0;
      win_d1    <= '0;
      win_d2    <= '0;
      win_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            len       <= bus.seq_len;
            cnt       <= '0;
            phase     <= '0;
            win_count <= '0;
            sr1       <= '0;
            sr2       <= '0;
            busy      <= 1'b1;
            if (bus.seq_len < LEN_W'(MIN_LEN)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end

        FILL: begin
          if (accept_c) begin
            sr1 <= sr2;
            sr2 <= bus.s_data;
            cnt <= cnt + LEN_W'(1);
            if (cnt == LEN_W'(FILL_CNT - 1)) begin
`ifdef SA_WINDOW_ZERO_PAD_EN
              if (last_c) begin
                state <= FLUSH;
              end else begin
                state <= STREAM;
              end
`else
              state <= STREAM;
`endif
            end
          end
        end

        STREAM: begin
          if (accept_c) begin
            sr1   <= sr2;
            sr2   <= bus.s_data;
            cnt   <= cnt + LEN_W'(1);
            phase <= phase_nxt_c;
            if (emit_c) begin
              win_valid <= 1'b1;
              win_d0    <= sr1;
              win_d1    <= sr2;
              win_d2    <= bus.s_data;
              win_count <= win_count + LEN_W'(1);
            end
            if (last_c) begin
`ifdef SA_WINDOW_ZERO_PAD_EN
              state <= FLUSH;
`else
              state <= DONE;
              done  <= 1'b1;
`endif
            end
          end
        end

`ifdef SA_WINDOW_ZERO_PAD_EN
        // Trailing zero shifted in after the last real sample.
        FLUSH: begin
          phase <= phase_nxt_c;
          if (emit_c) begin
            win_valid <= 1'b1;
            win_d0    <= sr1;
            win_d1    <= sr2;
            win_d2    <= '0;
            win_count <= win_count + LEN_W'(1);
          end
          state <= DONE;
          done  <= 1'b1;
        end
`endif

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_1d_window_feeder.sv
// Randomized self-checking bench for sa_1d_window_feeder: two instances (stride 1 and 2) share one
// stimulus stream and are checked against a padded-sequence window model.
module tb_sa_1d_window_feeder;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;
`ifdef SA_WINDOW_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  typedef struct {
    int           cyc;
    logic [7:0]   d0;
    logic [7:0]   d1;
    logic [7:0]   d2;
    logic [7:0]   cnt;
  } win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  win_t       obs_q[2][$];
  int         done_q[2][$];
  logic [7:0] smp[$];
  int         hs[$];
  int         start_cyc;
  win_t       mon_w;

  sa_1d_window_feeder_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus_a ();
  sa_1d_window_feeder_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus_b ();

  sa_1d_window_feeder #(.DATA_WIDTH(DW), .LEN_W(LW), .STRIDE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  sa_1d_window_feeder #(.DATA_WIDTH(DW), .LEN_W(LW), .STRIDE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  assign bus_b.start   = bus_a.start;
  assign bus_b.seq_len = bus_a.seq_len;
  assign bus_b.s_valid = bus_a.s_valid;
  assign bus_b.s_data  = bus_a.s_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Window/done monitor; cyc at the negedge names the edge that produced the output.
  always @(negedge clk) begin
    if (bus_a.win_valid === 1'b1) begin
      mon_w.cyc = cyc; mon_w.d0 = bus_a.win_d0; mon_w.d1 = bus_a.win_d1;
      mon_w.d2 = bus_a.win_d2; mon_w.cnt = bus_a.win_count;
      obs_q[0].push_back(mon_w);
    end
    if (bus_b.win_valid === 1'b1) begin
      mon_w.cyc = cyc; mon_w.d0 = bus_b.win_d0; mon_w.d1 = bus_b.win_d1;
      mon_w.d2 = bus_b.win_d2; mon_w.cnt = bus_b.win_count;
      obs_q[1].push_back(mon_w);
    end
    if (bus_a.done === 1'b1) done_q[0].push_back(cyc);
    if (bus_b.done === 1'b1) done_q[1].push_back(cyc);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // One framed sequence: drives smp[0..n-1], then compares both instances with the model.
  task automatic run_sequence(input string name, input int n, input int valid_pct);
    int         acc;
    int         guard;
    bit         short_seq;
    bit         v;
    int         st;
    int         j;
    int         exp_done;
    int         nexp;
    logic [7:0] pd[$];
    win_t       e;
    win_t       o;
    logic [7:0] fin_wc[2];
    logic       fin_busy[2];

    short_seq = (n < 3 - 2 * PAD);
    hs.delete();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      obs_q[d].delete();
      done_q[d].delete();
    end
    bus_a.start   = 1'b1;
    bus_a.seq_len = LW'(n);
    bus_a.s_valid = 1'b1;
    bus_a.s_data  = 8'($urandom);
    start_cyc     = cyc + 1;
    acc   = 0;
    guard = 0;
    while (!short_seq && acc < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      bus_a.start   = ($urandom_range(0, 3) == 0);
      bus_a.seq_len = 8'($urandom);
      tests++;
      if (bus_a.s_ready !== 1'b1 || bus_b.s_ready !== 1'b1) begin
        fails++;
        $display("FAIL %s ready_in_seq: got %b/%b want 1/1", name, bus_a.s_ready, bus_b.s_ready);
      end
      if (valid_pct < 0) v = ((guard % 2) == 1);
      else               v = ($urandom_range(0, 99) < valid_pct);
      bus_a.s_valid = v;
      bus_a.s_data  = v ? smp[acc] : 8'($urandom);
      if (v) begin
        hs.push_back(cyc + 1);
        acc++;
      end
    end
    if (guard >= 2000) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: accepted %0d want %0d", name, acc, n);
    end
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      bus_a.start   = 1'b0;
      bus_a.s_valid = 1'($urandom);
      bus_a.s_data  = 8'($urandom);
      tests++;
      if (bus_a.s_ready !== 1'b0 || bus_b.s_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s ready_idle: got %b/%b want 0/0", name, bus_a.s_ready, bus_b.s_ready);
      end
    end
    bus_a.s_valid = 1'b0;
    fin_wc[0]   = bus_a.win_count;
    fin_wc[1]   = bus_b.win_count;
    fin_busy[0] = bus_a.busy;
    fin_busy[1] = bus_b.busy;

    // Model: windows are every STRIDE-th 3-slice of the (optionally zero-padded) sample list.
    pd.delete();
    if (PAD == 1) pd.push_back(8'd0);
    foreach (smp[k]) if (k < n) pd.push_back(smp[k]);
    if (PAD == 1) pd.push_back(8'd0);
    exp_done = short_seq ? start_cyc : (hs[n-1] + PAD);

    for (int d = 0; d < 2; d++) begin
      st   = (d == 0) ? 1 : 2;
      nexp = 0;
      for (int i = 0; i + 2 < pd.size(); i += st) begin
        j     = i + 2 - PAD;
        e.cyc = (j < n) ? hs[j] : (hs[n-1] + 1);
        e.d0  = pd[i];
        e.d1  = pd[i+1];
        e.d2  = pd[i+2];
        e.cnt = 8'(nexp + 1);
        if (nexp < obs_q[d].size()) begin
          o = obs_q[d][nexp];
          tests++;
          if (o.cyc != e.cyc || o.d0 !== e.d0 || o.d1 !== e.d1 || o.d2 !== e.d2 || o.cnt !== e.cnt) begin
            fails++;
            $display("FAIL %s win s%0d #%0d: got cyc%0d (%0d,%0d,%0d) cnt%0d want cyc%0d (%0d,%0d,%0d) cnt%0d",
                     name, st, nexp, o.cyc, o.d0, o.d1, o.d2, o.cnt, e.cyc, e.d0, e.d1, e.d2, e.cnt);
          end
        end
        nexp++;
      end
      tests++;
      if (obs_q[d].size() != nexp) begin
        fails++;
        $display("FAIL %s nwin s%0d: got %0d want %0d", name, st, obs_q[d].size(), nexp);
      end
      tests++;
      if (done_q[d].size() != 1 || done_q[d][0] != exp_done) begin
        fails++;
        $display("FAIL %s done s%0d: got %0d pulses first cyc%0d want 1 pulse cyc%0d", name, st,
                 done_q[d].size(), (done_q[d].size() > 0) ? done_q[d][0] : -1, exp_done);
      end
      tests++;
      if (fin_wc[d] !== 8'(nexp) || fin_busy[d] !== 1'b0) begin
        fails++;
        $display("FAIL %s final s%0d: got win_count %0d busy %b want %0d busy 0", name, st,
                 fin_wc[d], fin_busy[d], nexp);
      end
    end
  endtask

  task automatic test_reset();
    bus_a.start = 1'b0; bus_a.seq_len = '0; bus_a.s_valid = 1'b0; bus_a.s_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus_a.s_ready, bus_a.win_valid, bus_a.win_d0, bus_a.win_d1, bus_a.win_d2, bus_a.busy,
         bus_a.done, bus_a.win_count, bus_b.s_ready, bus_b.win_valid, bus_b.busy, bus_b.done,
         bus_b.win_count} !== 48'd0) begin
      fails++;
      $display("FAIL reset_state: got ready%b wv%b busy%b done%b wc%0d want all 0",
               bus_a.s_ready, bus_a.win_valid, bus_a.busy, bus_a.done, bus_a.win_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    smp.delete();
    for (int i = 2; i <= 10; i++) smp.push_back(8'(i));
    run_sequence("back_to_back", 9, 100);
  endtask

  task automatic test_stall();
    smp.delete();
    for (int i = 2; i <= 10; i++) smp.push_back(8'(i));
    run_sequence("stall_alt", 9, -1);
  endtask

  task automatic test_short();
    smp.delete();
    smp.push_back(8'd11);
    smp.push_back(8'd12);
    run_sequence("short_len2", 2, 100);
    run_sequence("short_len1", 1, 100);
    run_sequence("short_len0", 0, 100);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.seq_len = 8'd9; bus_a.s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_a.start = 1'b0; bus_a.s_valid = 1'b1; bus_a.s_data = 8'(20 + i);
    end
    @(negedge clk);
    bus_a.s_valid = 1'b0;
    tests++;
    if (bus_a.win_valid !== 1'b1 || bus_a.busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: got win_valid %b busy %b want 1 1", bus_a.win_valid, bus_a.busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus_a.s_ready, bus_a.win_valid, bus_a.win_d0, bus_a.win_d1, bus_a.win_d2, bus_a.busy,
         bus_a.done, bus_a.win_count, bus_b.s_ready, bus_b.win_valid, bus_b.win_d0, bus_b.win_d1,
         bus_b.win_d2, bus_b.busy, bus_b.done, bus_b.win_count} !== 72'd0) begin
      fails++;
      $display("FAIL reset_mid_async: got wv%b d(%0d,%0d,%0d) busy%b wc%0d want all 0",
               bus_a.win_valid, bus_a.win_d0, bus_a.win_d1, bus_a.win_d2, bus_a.busy, bus_a.win_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    smp.delete();
    smp.push_back(8'd1); smp.push_back(8'd2); smp.push_back(8'd3);
    run_sequence("after_reset", 3, 100);
  endtask

  task automatic test_pad_example();
    smp.delete();
    smp.push_back(8'd5); smp.push_back(8'd6); smp.push_back(8'd7);
    run_sequence("len3_567", 3, 100);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 24);
      smp.delete();
      for (int i = 0; i < n; i++) smp.push_back(8'($urandom));
      run_sequence("random", n, $urandom_range(30, 100));
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_short();
    test_reset_mid();
    test_pad_example();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
